lm_sm_sequencer: RTL and testbench

LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

---
 rtl/lm_sm_sequencer_pkg.sv | 14 +
 rtl/lmsm_prio_enc.sv | 19 +
 rtl/lm_sm_sequencer.sv | 127 ++++++++++++
 tb/tb_lm_sm_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lm_sm_sequencer_pkg.sv
// lm_sm_sequencer_pkg: shared state encoding and widths for the load/store-multiple sequencer.
package lm_sm_sequencer_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/lmsm_prio_enc.sv
// lmsm_prio_enc: lowest-set-bit priority encoder over the 8-bit register mask (R0 wins).
module lmsm_prio_enc
    import lm_sm_sequencer_pkg::*;
(
    input  logic [7:0]       mask_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        idx_o = '0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_i[i]) idx_o = IDX_W'(i);
        end
    end

    assign valid_o = |mask_i;

endmodule

// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: LM/SM multi-register memory transfer sequencer.
// Optional LMSM_ZERO_MASK_ERR_EN adds the err_o pulse for a zero-mask start.
module lm_sm_sequencer
    import lm_sm_sequencer_pkg::*;
#(
    parameter int ADDR_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              is_load_i,
    input  logic [7:0]        mask_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    output logic [IDX_W-1:0]  reg_read_addr_o,
    input  logic [DATA_W-1:0] reg_read_data_i,
    output logic              reg_write_en_o,
    output logic [IDX_W-1:0]  reg_write_dest_o,
    output logic [DATA_W-1:0] reg_write_data_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              done_o
`ifdef LMSM_ZERO_MASK_ERR_EN
    ,
    output logic              err_o
`endif
);

    state_e            state_q, state_d;
    logic              is_load_q, is_load_d;
    logic [7:0]        mask_q, mask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, wr_data_q, wr_data_d;
    logic [IDX_W-1:0]  idx_q, idx_d, wr_dest_q, wr_dest_d, enc_idx;
    logic              wr_en_q, wr_en_d, enc_valid, take_start, take_ack;

    assign take_start = state_q == IDLE && start_i;
    assign take_ack   = state_q == REQ && mem_ack_i;
    assign mask_d     = take_start ? mask_i : take_ack ? mask_q & ~(8'b1 << idx_q) : mask_q;

    // Encoding the next-cycle mask lets the register read for SM be captured on the entry edge.
    lmsm_prio_enc u_enc (
        .mask_i  (mask_d),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        idx_d     = idx_q;
        wr_en_d   = 1'b0;
        wr_dest_d = wr_dest_q;
        wr_data_d = wr_data_q;
        if (take_start || take_ack) begin
            state_d = enc_valid ? REQ : DONE;
            idx_d   = enc_idx;
            wdata_d = reg_read_data_i;
        end else if (state_q != REQ) begin
            state_d = IDLE;
        end
        if (take_start) begin
            is_load_d = is_load_i;
            addr_d    = base_addr_i;
        end
        // R7 is the PC: its load still consumes an access but is never written back.
        if (take_ack) begin
            addr_d    = addr_q + ADDR_W'(ADDR_STEP);
            wr_en_d   = is_load_q && idx_q != '1;
            wr_dest_d = idx_q;
            wr_data_d = mem_rdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            is_load_q <= 1'b0;
            mask_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_dest_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
            mask_q    <= mask_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            idx_q     <= idx_d;
            wr_en_q   <= wr_en_d;
            wr_dest_q <= wr_dest_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef LMSM_ZERO_MASK_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= take_start && !enc_valid;
    end

    assign err_o = err_q;
`endif

    assign busy_o           = state_q == REQ;
    assign done_o           = state_q == DONE;
    assign mem_req_o        = busy_o;
    assign mem_we_o         = busy_o && !is_load_q;
    assign mem_addr_o       = busy_o ? addr_q : '0;
    assign mem_wdata_o      = mem_we_o ? wdata_q : '0;
    assign reg_read_addr_o  = enc_idx;
    assign reg_write_en_o   = wr_en_q;
    assign reg_write_dest_o = wr_dest_q;
    assign reg_write_data_o = wr_data_q;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb_lm_sm_sequencer: scoreboard bench for lm_sm_sequencer with directed LM/SM vectors.
module tb_lm_sm_sequencer;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_t;

    typedef struct packed {
        logic [2:0]  dest;
        logic [15:0] data;
    } wr_t;

    typedef struct packed {
        logic [31:0] at;
        logic        e;
    } done_t;

`ifdef LMSM_ZERO_MASK_ERR_EN
    localparam bit ZERR = 1'b1;
`else
    localparam bit ZERR = 1'b0;
`endif

    logic        clk = 0, rst_n = 0, start = 0, is_load = 0, mem_ack = 0;
    logic [7:0]  mask = 0;
    logic [15:0] base = 0, mem_rdata = 0;
    logic [2:0]  rd_addr, wr_dest;
    logic [15:0] rd_data, wr_data, mem_addr, mem_wdata;
    logic        wr_en, mem_req, mem_we, busy, done;
`ifdef LMSM_ZERO_MASK_ERR_EN
    logic        err;
`endif
    logic [15:0] regs [8];

    mem_t        exp_mem [$];
    wr_t         exp_wr [$];
    done_t       exp_done [$];
    logic [15:0] rd_q [$];

    int applied = 0, miscompares = 0, cyc = 0, wait_n = 0, wcnt = 0, done_cnt = 0;
    logic        prev_req = 0, prev_ack = 0, prev_we = 0;
    logic [15:0] prev_addr = 0, prev_wdata = 0;
    mem_t        me;
    wr_t         we_;
    done_t       de;

    lm_sm_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (start),
        .is_load_i        (is_load),
        .mask_i           (mask),
        .base_addr_i      (base),
        .reg_read_addr_o  (rd_addr),
        .reg_read_data_i  (rd_data),
        .reg_write_en_o   (wr_en),
        .reg_write_dest_o (wr_dest),
        .reg_write_data_o (wr_data),
        .mem_req_o        (mem_req),
        .mem_we_o         (mem_we),
        .mem_addr_o       (mem_addr),
        .mem_wdata_o      (mem_wdata),
        .mem_ack_i        (mem_ack),
        .mem_rdata_i      (mem_rdata),
        .busy_o           (busy),
        .done_o           (done)
`ifdef LMSM_ZERO_MASK_ERR_EN
        ,
        .err_o            (err)
`endif
    );

    assign rd_data = regs[rd_addr];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory responder: acks after wait_n idle cycles of a pending request.
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            if (wcnt == wait_n) begin
                mem_ack = 1'b1;
                mem_rdata = rd_q.size() > 0 ? rd_q.pop_front() : 16'h0000;
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt = 0;
        end
    end

    // Monitor: pops and compares whenever the DUT presents a transaction.
    always @(negedge clk) begin
        if (mem_req && mem_ack) begin
            if (exp_mem.size() == 0) check("mem_unexpected", exp_mem.size(), 1);
            else begin
                me = exp_mem.pop_front();
                check("mem_we", mem_we, me.we);
                check("mem_addr", mem_addr, me.addr);
                if (me.we) check("mem_wdata", mem_wdata, me.wdata);
            end
        end
        if (wr_en) begin
            if (exp_wr.size() == 0) check("wr_unexpected", exp_wr.size(), 1);
            else begin
                we_ = exp_wr.pop_front();
                check("wr_dest", wr_dest, we_.dest);
                check("wr_data", wr_data, we_.data);
            end
        end
        if (done) begin
            done_cnt++;
            if (exp_done.size() == 0) check("done_unexpected", exp_done.size(), 1);
            else begin
                de = exp_done.pop_front();
                check("done_cycle", cyc, de.at);
`ifdef LMSM_ZERO_MASK_ERR_EN
                check("err", err, de.e);
`endif
            end
        end
        if (mem_req && prev_req && !prev_ack) begin
            check("hold_addr", mem_addr, prev_addr);
            check("hold_we", mem_we, prev_we);
            check("hold_wdata", mem_wdata, prev_wdata);
        end
        prev_req = mem_req;
        prev_ack = mem_ack;
        prev_we = mem_we;
        prev_addr = mem_addr;
        prev_wdata = mem_wdata;
    end

    task automatic drain();
        check("mem_left", exp_mem.size(), 0);
        check("wr_left", exp_wr.size(), 0);
        check("done_left", exp_done.size(), 0);
        exp_mem.delete();
        exp_wr.delete();
        exp_done.delete();
        rd_q.delete();
    endtask

    task automatic run(input logic ld, input logic [7:0] m, input logic [15:0] b,
                       input int w, input int lat, input logic e, input bit poke);
        int t, d0;
        @(posedge clk);
        #1;
        wait_n = w;
        t = cyc;
        d0 = done_cnt;
        exp_done.push_back('{at: t + lat, e: e});
        start = 1; is_load = ld; mask = m; base = b;
        @(posedge clk);
        #1;
        start = 0;
        if (poke) begin
            @(posedge clk);
            #1;
            check("busy_mid", busy, 1);
            start = 1; is_load = ~ld; mask = 8'hFF; base = 16'hDEAD;
            @(posedge clk);
            #1;
            start = 0;
        end
        for (int i = 0; i < 100 && done_cnt == d0; i++) @(negedge clk);
        check("done_seen", done_cnt != d0, 1);
        repeat (2) @(negedge clk);
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
        #3;
        check("rst_mem_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // LM, two registers, zero wait
        rd_q.push_back(16'hAAAA); rd_q.push_back(16'h5555);
        exp_mem.push_back('{we: 1'b0, addr: 16'h0040, wdata: 16'h0});
        exp_mem.push_back('{we: 1'b0, addr: 16'h0041, wdata: 16'h0});
        exp_wr.push_back('{dest: 3'd0, data: 16'hAAAA});
        exp_wr.push_back('{dest: 3'd2, data: 16'h5555});
        run(1'b1, 8'b0000_0101, 16'h0040, 0, 3, 1'b0, 1'b0);

        // SM R0/R7 with two wait cycles, start poked while busy
        regs[0] = 16'h1234; regs[7] = 16'h0010;
        exp_mem.push_back('{we: 1'b1, addr: 16'h0100, wdata: 16'h1234});
        exp_mem.push_back('{we: 1'b1, addr: 16'h0101, wdata: 16'h0010});
        run(1'b0, 8'h81, 16'h0100, 2, 7, 1'b0, 1'b1);

        // LM R7 only: access happens, no write-back
        rd_q.push_back(16'hBEEF);
        exp_mem.push_back('{we: 1'b0, addr: 16'h0200, wdata: 16'h0});
        run(1'b1, 8'h80, 16'h0200, 0, 2, 1'b0, 1'b0);

        // SM address wrap
        regs[0] = 16'hCAFE; regs[1] = 16'hF00D;
        exp_mem.push_back('{we: 1'b1, addr: 16'hFFFF, wdata: 16'hCAFE});
        exp_mem.push_back('{we: 1'b1, addr: 16'h0000, wdata: 16'hF00D});
        run(1'b0, 8'h03, 16'hFFFF, 0, 3, 1'b0, 1'b0);

        // zero mask
        run(1'b1, 8'h00, 16'h0500, 0, 1, ZERR, 1'b0);

        // reset during second access of mask FF
        rd_q.push_back(16'h1111);
        exp_mem.push_back('{we: 1'b0, addr: 16'h0300, wdata: 16'h0});
        exp_wr.push_back('{dest: 3'd0, data: 16'h1111});
        @(posedge clk);
        #1;
        wait_n = 1;
        start = 1; is_load = 1; mask = 8'hFF; base = 16'h0300;
        @(posedge clk);
        #1;
        start = 0;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            found = mem_req && mem_addr == 16'h0301;
        end
        check("second_access", found, 1);
        #2 rst_n = 0;
        #1;
        check("arst_mem_req", mem_req, 0);
        check("arst_busy", busy, 0);
        check("arst_mem_addr", mem_addr, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        check("post_rst_busy", busy, 0);
        drain();

        // normal transfer after reset release
        rd_q.push_back(16'h0F0F); rd_q.push_back(16'hF0F0);
        exp_mem.push_back('{we: 1'b0, addr: 16'h0040, wdata: 16'h0});
        exp_mem.push_back('{we: 1'b0, addr: 16'h0041, wdata: 16'h0});
        exp_wr.push_back('{dest: 3'd0, data: 16'h0F0F});
        exp_wr.push_back('{dest: 3'd2, data: 16'hF0F0});
        run(1'b1, 8'b0000_0101, 16'h0040, 0, 3, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
